// File: rtl/spike_window_counter_bank_if.sv
// Bus bundle for the spike window counter bank. The bench drives it as master.
// The counter bank is the slave.
interface spike_window_counter_bank_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 32
);
  logic                      reset_sim;
  logic [N_CH-1:0]           spike_in;
  logic [N_CH-1:0]           or_mask;
  logic                      window_tick;
  logic [(N_CH+1)*CNT_W-1:0] cnt_out;
  logic                      cnt_valid;
  logic [N_CH:0]             sat_flag;
  logic                      spike_out;

  modport master (
    output reset_sim, spike_in, or_mask, window_tick,
    input  cnt_out, cnt_valid, sat_flag, spike_out
  );

  modport slave (
    input  reset_sim, spike_in, or_mask, window_tick,
    output cnt_out, cnt_valid, sat_flag, spike_out
  );
endinterface

// File: rtl/spike_window_counter_bank.sv
// Multi-channel windowed spike counter with a mask-selected OR-combined channel.
// Counters saturate and set sticky flags. A stretched combined spike drives the cross-board pin.
module spike_window_counter_bank #(
  parameter int              N_CH        = 3,
  parameter int              CNT_W       = 32,
  parameter logic [N_CH-1:0] EXT_MASK    = '0,
  parameter int              SYNC_STAGES = 2,
  parameter int              STRETCH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_global,
  spike_window_counter_bank_if.slave   bus
);

  localparam int STR_W = $clog2(STRETCH + 1);

  logic [N_CH-1:0]  w_c;
  logic [N_CH-1:0]  r_cD;
  logic [N_CH-1:0]  w_e;
  logic             w_cc;
  logic             r_ccD;
  logic             w_ec;
  logic [N_CH:0]    w_inc;

  logic [CNT_W-1:0] r_acc    [N_CH+1];
  logic [CNT_W-1:0] r_cntOut [N_CH+1];
  logic [CNT_W-1:0] w_sum    [N_CH+1];
  logic [N_CH:0]    w_ovf;
  logic [N_CH:0]    r_satFlag;
  logic             r_cntValid;

  logic [STR_W-1:0] r_stretchCnt;
  logic [STR_W-1:0] w_stretchNext;
  logic             r_spikeOut;

  // Internal channels get a single register. Cross-board channels get a full synchronizer chain.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cond
    if (EXT_MASK[gi]) begin : g_ext
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) r_sync <= '0;
        else              r_sync <= {r_sync[SYNC_STAGES-2:0], bus.spike_in[gi]};
      end
      assign w_c[gi] = r_sync[SYNC_STAGES-1];
    end else begin : g_int
      logic r_sync;
      always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) r_sync <= 1'b0;
        else              r_sync <= bus.spike_in[gi];
      end
      assign w_c[gi] = r_sync;
    end
  end

  // The combined channel ORs levels before edge detection, so overlapping spikes on different channels count once.
  assign w_cc  = |(w_c & bus.or_mask);
  assign w_e   = w_c & ~r_cD;
  assign w_ec  = w_cc & ~r_ccD;
  assign w_inc = {w_ec, w_e};

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_cD  <= '0;
      r_ccD <= 1'b0;
    end else begin
      r_cD  <= w_c;
      r_ccD <= w_cc;
    end
  end

  always_comb begin
    w_ovf = '0;
    for (int j = 0; j <= N_CH; j++) begin
      w_ovf[j] = w_inc[j] & (&r_acc[j]);
      w_sum[j] = w_ovf[j] ? r_acc[j] : r_acc[j] + CNT_W'(w_inc[j]);
    end
  end

  // The closing window latches acc + edge, so an edge that coincides with a tick lands in the closing window.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      for (int j = 0; j <= N_CH; j++) begin
        r_acc[j]    <= '0;
        r_cntOut[j] <= '0;
      end
      r_satFlag  <= '0;
      r_cntValid <= 1'b0;
    end else if (bus.reset_sim) begin
      for (int j = 0; j <= N_CH; j++) begin
        r_acc[j]    <= '0;
        r_cntOut[j] <= '0;
      end
      r_satFlag  <= '0;
      r_cntValid <= 1'b0;
    end else begin
      r_satFlag  <= r_satFlag | w_ovf;
      r_cntValid <= bus.window_tick;
      for (int j = 0; j <= N_CH; j++) begin
        if (bus.window_tick) begin
          r_cntOut[j] <= w_sum[j];
          r_acc[j]    <= '0;
        end else begin
          r_acc[j]    <= w_sum[j];
        end
      end
    end
  end

  // A new combined edge reloads the counter, so retriggers extend the pulse without a gap.
  always_comb begin
    w_stretchNext = r_stretchCnt;
    if (w_ec)                     w_stretchNext = STR_W'(STRETCH);
    else if (r_stretchCnt != '0)  w_stretchNext = r_stretchCnt - STR_W'(1);
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_stretchCnt <= '0;
      r_spikeOut   <= 1'b0;
    end else begin
      r_stretchCnt <= w_stretchNext;
      r_spikeOut   <= (w_stretchNext != '0);
    end
  end

  for (genvar gj = 0; gj <= N_CH; gj++) begin : g_out
    assign bus.cnt_out[gj*CNT_W +: CNT_W] = r_cntOut[gj];
  end

  assign bus.cnt_valid = r_cntValid;
  assign bus.sat_flag  = r_satFlag;
  assign bus.spike_out = r_spikeOut;

endmodule
